// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants, FSM state type and the shared
// seven-segment decode function for the seg7_to_bcd block.
// Optional feature macro: SEG7_TO_BCD_HEX_EN (adds A..F decoding).
package seg7_pkg;

    // Segment patterns, active-high, bit6=g ... bit0=a
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;

    // Output handshake states
    typedef enum logic [1:0] {
        TRACK = 2'd0,
        EMIT  = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] bcd;
        logic       error;
    } decode_t;

    // Map a segment pattern to its digit; unknown non-blank patterns give F/error.
    function automatic decode_t decode(input logic [6:0] pattern);
        decode_t result;
        result.bcd   = 4'hF;
        result.error = 1'b1;
        case (pattern)
            SEG_BLANK: begin result.bcd = 4'h0; result.error = 1'b0; end
            SEG_0:     begin result.bcd = 4'h0; result.error = 1'b0; end
            SEG_1:     begin result.bcd = 4'h1; result.error = 1'b0; end
            SEG_2:     begin result.bcd = 4'h2; result.error = 1'b0; end
            SEG_3:     begin result.bcd = 4'h3; result.error = 1'b0; end
            SEG_4:     begin result.bcd = 4'h4; result.error = 1'b0; end
            SEG_5:     begin result.bcd = 4'h5; result.error = 1'b0; end
            SEG_6:     begin result.bcd = 4'h6; result.error = 1'b0; end
            SEG_7:     begin result.bcd = 4'h7; result.error = 1'b0; end
            SEG_8:     begin result.bcd = 4'h8; result.error = 1'b0; end
            SEG_9:     begin result.bcd = 4'h9; result.error = 1'b0; end
`ifdef SEG7_TO_BCD_HEX_EN
            SEG_A:     begin result.bcd = 4'hA; result.error = 1'b0; end
            SEG_B:     begin result.bcd = 4'hB; result.error = 1'b0; end
            SEG_C:     begin result.bcd = 4'hC; result.error = 1'b0; end
            SEG_D:     begin result.bcd = 4'hD; result.error = 1'b0; end
            SEG_E:     begin result.bcd = 4'hE; result.error = 1'b0; end
            SEG_F:     begin result.bcd = 4'hF; result.error = 1'b0; end
`endif
            default:   begin result.bcd = 4'hF; result.error = 1'b1; end
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// seg7_stable_filter: tracks the most recently sampled segment pattern and
// how many consecutive edges it has been seen, saturating at STABLE_CYCLES.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] leds,
    output logic [6:0] cur,
    output logic       stable
);

    localparam logic [7:0] STABLE_COUNT = 8'(STABLE_CYCLES);

    logic [6:0] r_cur;
    logic [7:0] r_cnt;

    // Restart the count on any change of pattern, otherwise count up to the threshold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur <= SEG_BLANK;
            r_cnt <= 8'd0;
        end else if (leds != r_cur) begin
            r_cur <= leds;
            r_cnt <= 8'd1;
        end else if (r_cnt != STABLE_COUNT) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign cur    = r_cur;
    assign stable = (r_cnt == STABLE_COUNT);

endmodule

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: debounces a seven-segment pattern and emits each newly
// stable digit once over a valid/ready handshake. Blank frames re-arm
// emission so a repeated digit separated by a blank is reported again.
// Optional feature macro: SEG7_TO_BCD_HEX_EN (decode A..F as digits).
module seg7_to_bcd
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] leds,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] bcd,
    output logic       error
);

    logic [6:0] w_cur;
    logic       w_stable;
    decode_t    w_decoded;

    state_t     r_state;
    logic [6:0] r_lastEmit;
    logic       r_valid;
    logic [3:0] r_bcd;
    logic       r_error;

    seg7_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .leds   (leds),
        .cur    (w_cur),
        .stable (w_stable)
    );

    assign w_decoded = decode(w_cur);

    // Handshake FSM: emit new stable patterns, hold until accepted, then wait for a change
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= TRACK;
            r_lastEmit <= SEG_BLANK;
            r_valid    <= 1'b0;
            r_bcd      <= 4'h0;
            r_error    <= 1'b0;
        end else begin
            unique case (r_state)
                TRACK: begin
                    if (w_stable && (w_cur != SEG_BLANK) && (w_cur != r_lastEmit)) begin
                        r_state    <= EMIT;
                        r_valid    <= 1'b1;
                        r_bcd      <= w_decoded.bcd;
                        r_error    <= w_decoded.error;
                        r_lastEmit <= w_cur;
                    end else if (w_stable && (w_cur == SEG_BLANK)) begin
                        r_lastEmit <= SEG_BLANK;
                    end
                end
                EMIT: begin
                    if (ready) begin
                        r_state <= DONE;
                        r_valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (w_cur != r_lastEmit) begin
                        r_state <= TRACK;
                    end
                end
                default: begin
                    r_state <= TRACK;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid = r_valid;
    assign bcd   = r_bcd;
    assign error = r_error;

endmodule

// File: tb/tb_seg7_to_bcd.sv
// tb_seg7_to_bcd: directed stimulus for seg7_to_bcd with a scoreboard of
// expected {bcd,error} pairs consumed by a handshake monitor, plus timed
// checks of valid latency, backpressure and asynchronous reset.
module tb_seg7_to_bcd;

    logic       clk;
    logic       reset;
    logic [6:0] leds;
    logic       ready;
    logic       valid;
    logic [3:0] bcd;
    logic       error;

    int checkCount = 0;
    int failCount  = 0;
    int outCount   = 0;
    int savedCount = 0;

    logic [4:0] sbQueue[$];
    logic [4:0] expItem;

    logic [6:0] digitPat[10];

    seg7_to_bcd #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .leds  (leds),
        .ready (ready),
        .valid (valid),
        .bcd   (bcd),
        .error (error)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] pattern);
        leds = pattern;
    endtask

    task automatic pushExpected(input logic [3:0] expBcd, input logic expErr);
        sbQueue.push_back({expBcd, expErr});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted transfer must match the oldest expectation
    always @(negedge clk) begin
        if (reset && valid && ready) begin
            outCount++;
            checkOutput("sb_has_expected", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                expItem = sbQueue.pop_front();
                checkOutput("out_bcd", 32'(bcd), 32'(expItem[4:1]));
                checkOutput("out_error", 32'(error), 32'(expItem[0]));
            end
        end
    end

    // Directed test sequence
    initial begin
        digitPat[0] = 7'b0111111; digitPat[1] = 7'b0000110;
        digitPat[2] = 7'b1011011; digitPat[3] = 7'b1001111;
        digitPat[4] = 7'b1100110; digitPat[5] = 7'b1101101;
        digitPat[6] = 7'b1111101; digitPat[7] = 7'b0000111;
        digitPat[8] = 7'b1111111; digitPat[9] = 7'b1101111;

        reset = 1'b0;
        leds  = 7'b0000000;
        ready = 1'b1;
        #1;
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_bcd", 32'(bcd), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(6);
        checkOutput("blank_no_valid", 32'(valid), 32'd0);

        // Unrecognised pattern then digit 2, with exact latency checks
        pushExpected(4'hF, 1'b1);
        applyStimulus(7'b0110000);
        tick(7);
        pushExpected(4'h2, 1'b0);
        applyStimulus(7'b1011011);
        tick(4);
        checkOutput("lat_before_valid", 32'(valid), 32'd0);
        tick(1);
        checkOutput("lat_valid", 32'(valid), 32'd1);
        checkOutput("lat_bcd", 32'(bcd), 32'd2);
        checkOutput("lat_error", 32'(error), 32'd0);
        tick(1);
        checkOutput("lat_valid_drop", 32'(valid), 32'd0);
        tick(2);
        checkOutput("s1_sb_empty", 32'(sbQueue.size()), 32'd0);

        // Glitch: 3 for two cycles must not be emitted
        pushExpected(4'h4, 1'b0);
        applyStimulus(7'b1001111);
        tick(2);
        applyStimulus(7'b1100110);
        tick(7);
        checkOutput("glitch_sb_empty", 32'(sbQueue.size()), 32'd0);

        // All ten digits back to back
        for (int i = 0; i < 10; i++) begin
            pushExpected(4'(i), 1'b0);
            applyStimulus(digitPat[i]);
            tick(7);
        end
        checkOutput("digits_sb_empty", 32'(sbQueue.size()), 32'd0);

        // Hex patterns A and E
`ifdef SEG7_TO_BCD_HEX_EN
        pushExpected(4'hA, 1'b0);
`else
        pushExpected(4'hF, 1'b1);
`endif
        applyStimulus(7'b1110111);
        tick(7);
`ifdef SEG7_TO_BCD_HEX_EN
        pushExpected(4'hE, 1'b0);
`else
        pushExpected(4'hF, 1'b1);
`endif
        applyStimulus(7'b1111001);
        tick(7);
        checkOutput("hex_sb_empty", 32'(sbQueue.size()), 32'd0);

        // Backpressure: 8 held while 7 stabilises behind it
        ready = 1'b0;
        pushExpected(4'h8, 1'b0);
        pushExpected(4'h7, 1'b0);
        applyStimulus(7'b1111111);
        tick(6);
        checkOutput("bp_valid", 32'(valid), 32'd1);
        checkOutput("bp_bcd", 32'(bcd), 32'd8);
        applyStimulus(7'b0000111);
        tick(8);
        checkOutput("bp_hold_valid", 32'(valid), 32'd1);
        checkOutput("bp_hold_bcd", 32'(bcd), 32'd8);
        ready = 1'b1;
        tick(1);
        checkOutput("bp_drop", 32'(valid), 32'd0);
        tick(2);
        checkOutput("bp_next_valid", 32'(valid), 32'd1);
        checkOutput("bp_next_bcd", 32'(bcd), 32'd7);
        tick(3);
        checkOutput("bp_sb_empty", 32'(sbQueue.size()), 32'd0);

        // Repeated 5 separated by blank emits twice, held 5 emits once
        pushExpected(4'h5, 1'b0);
        applyStimulus(7'b1101101);
        tick(7);
        applyStimulus(7'b0000000);
        tick(5);
        pushExpected(4'h5, 1'b0);
        applyStimulus(7'b1101101);
        tick(7);
        checkOutput("rep_sb_empty", 32'(sbQueue.size()), 32'd0);
        savedCount = outCount;
        tick(10);
        checkOutput("held_no_repeat", 32'(outCount), 32'(savedCount));

        // Asynchronous reset in the middle of EMIT
        ready = 1'b0;
        applyStimulus(7'b1101111);
        tick(5);
        checkOutput("rst_pre_valid", 32'(valid), 32'd1);
        checkOutput("rst_pre_bcd", 32'(bcd), 32'd9);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_async_valid", 32'(valid), 32'd0);
        checkOutput("rst_async_bcd", 32'(bcd), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        ready = 1'b1;
        pushExpected(4'h9, 1'b0);
        tick(4);
        checkOutput("rst_re_before", 32'(valid), 32'd0);
        tick(1);
        checkOutput("rst_re_valid", 32'(valid), 32'd1);
        checkOutput("rst_re_bcd", 32'(bcd), 32'd9);
        tick(3);
        checkOutput("rst_sb_empty", 32'(sbQueue.size()), 32'd0);

        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
